adpll_gear_controller: RTL and testbench

//  Parametrised loop controller for the ring-oscillator ADPLL. Sits between the phase detector and the ring oscillator

---
 rtl/adpll_gear_controller.sv | 268 ++++++++++++++++++++++++++
 tb/tb_adpll_gear_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adpll_gear_controller.sv
// adpll_gear_controller
// Loop controller for the ring-oscillator ADPLL. It takes signed phase-error
// samples and runs them through a two-gear shift-gain PI filter with
// integrator anti-windup. A lock-detect FSM selects the gear. The filter
// output is biased and saturated into the RO frequency-select word.
//
// Pipeline for a sample accepted at edge N:
//   N   : sample captured together with the gear of the state held at that edge
//   N+1 : integrator and FSM updated, and P+I sum registered
//   N+2 : control word biased, clamped and registered; dco_valid_o pulses
module adpll_gear_controller #(
    parameter int RO_WIDTH     = 5,
    parameter int ERROR_WIDTH  = 8,
    parameter int FRAC_BITS    = 4,
    parameter int INT_WIDTH    = 16,
    parameter int BIAS         = 16,
    parameter int KP_ACQ_SHIFT = 0,
    parameter int KI_ACQ_SHIFT = 2,
    parameter int KP_TRK_SHIFT = 1,
    parameter int KI_TRK_SHIFT = 4,
    parameter int TRACK_THRESH = 4,
    parameter int LOCK_THRESH  = 1,
    parameter int TRACK_COUNT  = 4,
    parameter int LOCK_COUNT   = 16
) (
    input  logic                          fpga_clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic signed [ERROR_WIDTH-1:0] error_i,
    input  logic                          error_valid_i,
    output logic        [RO_WIDTH-1:0]    dco_cc_o,
    output logic                          dco_valid_o,
    output logic                          locked_o,
    output logic        [1:0]             state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    // Window counter wide enough to reach either target without wrapping.
    localparam int CNT_MAX = (LOCK_COUNT > TRACK_COUNT) ? LOCK_COUNT : TRACK_COUNT;
    localparam int CW      = $clog2(CNT_MAX + 1) + 1;
    // P+I sum carries two guard bits above the integrator.
    localparam int PW      = INT_WIDTH + 2;
    // Bias subtraction width: room for the sum plus the bias without overflow.
    localparam int SW      = INT_WIDTH + RO_WIDTH + 4;

    localparam logic [ERROR_WIDTH-1:0] ERR_MIN  = {1'b1, {(ERROR_WIDTH-1){1'b0}}};
    localparam logic [ERROR_WIDTH-1:0] ERR_MAX  = {1'b0, {(ERROR_WIDTH-1){1'b1}}};
    localparam logic [ERROR_WIDTH-1:0] TRACK_TH = ERROR_WIDTH'(TRACK_THRESH);
    localparam logic [ERROR_WIDTH-1:0] LOCK_TH  = ERROR_WIDTH'(LOCK_THRESH);
    localparam logic [CW-1:0]          TRACK_CNT = CW'(TRACK_COUNT);
    localparam logic [CW-1:0]          LOCK_CNT  = CW'(LOCK_COUNT);

    localparam logic signed [INT_WIDTH-1:0] INT_POS = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic signed [INT_WIDTH-1:0] INT_NEG = {1'b1, {(INT_WIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0]        BIAS_S  = SW'(BIAS);
    localparam logic signed [SW-1:0]        RO_MAX_S = SW'((1 << RO_WIDTH) - 1);
    localparam logic [RO_WIDTH-1:0]         RO_MAX  = '1;
    localparam logic [RO_WIDTH-1:0]         BIAS_RO = RO_WIDTH'(BIAS);

    // FSM state and lock-window counter
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        cnt_inc;

    // Stage 1: captured sample and its gear
    logic                          s1_valid_q;
    logic signed [ERROR_WIDTH-1:0] s1_err_q;
    logic                          s1_trk_q;

    // Stage 2: integrator and registered P+I sum
    logic signed [INT_WIDTH-1:0]   integ_q, integ_d;
    logic                          s2_valid_q;
    logic signed [PW-1:0]          s2_pi_q;

    // Stage 3: output word
    logic [RO_WIDTH-1:0]           dco_q, dco_d;
    logic                          dco_valid_q;

    // Datapath intermediates
    logic                          accept;
    logic [ERROR_WIDTH-1:0]        s1_abs;
    logic                          in_track, in_lock;
    logic signed [INT_WIDTH-1:0]   e_ext, e_fix, p_term, i_inc;
    logic signed [INT_WIDTH:0]     isum;
    logic signed [INT_WIDTH-1:0]   isat;
    logic                          e_pos, e_neg, hold;
    logic signed [PW-1:0]          pi_sum;
    logic signed [PW-1:0]          ctrl;
    logic signed [SW-1:0]          raw;
    logic [RO_WIDTH-1:0]           dco_clamped;

    // Samples are only taken while the loop is running.
    assign accept = error_valid_i & enable_i & (state_q != ST_IDLE);

    // Saturating magnitude of the captured sample and its window tests
    always_comb begin
        s1_abs = s1_err_q;
        if (s1_err_q == ERR_MIN) begin
            s1_abs = ERR_MAX;
        end else if (s1_err_q[ERROR_WIDTH-1]) begin
            s1_abs = -s1_err_q;
        end
        in_track = (s1_abs <= TRACK_TH);
        in_lock  = (s1_abs <= LOCK_TH);
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    end

    // PI arithmetic. The sign of the raw sample is used, so -2^(W-1) is not clamped here.
    always_comb begin
        e_ext  = {{(INT_WIDTH-ERROR_WIDTH){s1_err_q[ERROR_WIDTH-1]}}, s1_err_q};
        e_fix  = e_ext <<< FRAC_BITS;
        p_term = s1_trk_q ? (e_fix >>> KP_TRK_SHIFT) : (e_fix >>> KP_ACQ_SHIFT);
        i_inc  = s1_trk_q ? (e_fix >>> KI_TRK_SHIFT) : (e_fix >>> KI_ACQ_SHIFT);

        isum = {integ_q[INT_WIDTH-1], integ_q} + {i_inc[INT_WIDTH-1], i_inc};
        if (isum[INT_WIDTH] != isum[INT_WIDTH-1]) begin
            isat = isum[INT_WIDTH] ? INT_NEG : INT_POS;
        end else begin
            isat = isum[INT_WIDTH-1:0];
        end

        // Freeze the integrator while the output is pinned at a rail and the
        // error pushes further into that rail.
        e_pos = ~s1_err_q[ERROR_WIDTH-1] & (s1_err_q != '0);
        e_neg = s1_err_q[ERROR_WIDTH-1];
        hold  = ((dco_q == '0) & e_pos) | ((dco_q == RO_MAX) & e_neg);

        integ_d = integ_q;
        if (s1_valid_q && !hold) begin
            integ_d = isat;
        end

        pi_sum = {{2{integ_d[INT_WIDTH-1]}}, integ_d} + {{2{p_term[INT_WIDTH-1]}}, p_term};
    end

    // Bias and clamp the registered P+I sum at full precision.
    always_comb begin
        ctrl = s2_pi_q >>> FRAC_BITS;
        raw  = BIAS_S - {{(SW-PW){ctrl[PW-1]}}, ctrl};
        if (raw[SW-1]) begin
            dco_clamped = '0;
        end else if (raw > RO_MAX_S) begin
            dco_clamped = RO_MAX;
        end else begin
            dco_clamped = raw[RO_WIDTH-1:0];
        end
        dco_d = dco_q;
        if (s2_valid_q) begin
            dco_d = dco_clamped;
        end
    end

    // Next state and lock-window counter, advanced only by processed samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    cnt_d   = '0;
                end
                ST_ACQUIRE: begin
                    if (s1_valid_q) begin
                        if (!in_track) begin
                            cnt_d = '0;
                        end else if (cnt_inc >= TRACK_CNT) begin
                            state_d = ST_TRACK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_TRACK: begin
                    if (s1_valid_q) begin
                        if (!in_track) begin
                            state_d = ST_ACQUIRE;
                            cnt_d   = '0;
                        end else if (!in_lock) begin
                            cnt_d = '0;
                        end else if (cnt_inc >= LOCK_CNT) begin
                            state_d = ST_LOCKED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (s1_valid_q) begin
                        if (!in_track) begin
                            state_d = ST_ACQUIRE;
                            cnt_d   = '0;
                        end else if (!in_lock) begin
                            state_d = ST_TRACK;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pipeline valids, integrator and output; disable flushes like reset
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i || !enable_i) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            dco_valid_q <= 1'b0;
            integ_q     <= '0;
            dco_q       <= BIAS_RO;
        end else begin
            s1_valid_q  <= accept;
            s2_valid_q  <= s1_valid_q;
            dco_valid_q <= s2_valid_q;
            integ_q     <= integ_d;
            dco_q       <= dco_d;
        end
    end

    // Sample capture with gear snapshot, and P+I sum register
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            s1_err_q <= '0;
            s1_trk_q <= 1'b0;
            s2_pi_q  <= '0;
        end else begin
            if (accept) begin
                s1_err_q <= error_i;
                s1_trk_q <= (state_q == ST_TRACK) || (state_q == ST_LOCKED);
            end
            if (s1_valid_q) begin
                s2_pi_q <= pi_sum;
            end
        end
    end

    assign dco_cc_o    = dco_q;
    assign dco_valid_o = dco_valid_q;
    assign locked_o    = (state_q == ST_LOCKED);
    assign state_o     = state_q;

endmodule

// File: tb/tb_adpll_gear_controller.sv
// Bench for adpll_gear_controller: directed scenarios followed by random
// traffic. All results are compared against a transaction-level model.
module tb_adpll_gear_controller;

    localparam int BIAS   = 16;
    localparam int DCOMAX = 31;

    logic              clk;
    logic              reset_i;
    logic              enable_i;
    logic signed [7:0] error_i;
    logic              error_valid_i;
    logic [4:0]        dco_cc_o;
    logic              dco_valid_o;
    logic              locked_o;
    logic [1:0]        state_o;

    adpll_gear_controller #(
        .RO_WIDTH    (5),
        .ERROR_WIDTH (8),
        .FRAC_BITS   (4),
        .INT_WIDTH   (16),
        .BIAS        (BIAS)
    ) dut (
        .fpga_clk_i    (clk),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .error_i       (error_i),
        .error_valid_i (error_valid_i),
        .dco_cc_o      (dco_cc_o),
        .dco_valid_o   (dco_valid_o),
        .locked_o      (locked_o),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // A sample accepted at cycle t is filtered at t+1 and seen on the output at t+2.
    typedef struct { int e; int st; int due; } samp_t;
    typedef struct { int v; int due; } out_t;

    samp_t pend[$];
    out_t  outq[$];
    int    cyc = 0;
    int    m_state = 0;  // 0 idle, 1 acquire, 2 track, 3 locked
    int    m_cnt = 0;
    int    m_integ = 0;
    int    m_dco = BIAS;
    int    m_valid = 0;

    task automatic m_flush();
        m_state = 0; m_cnt = 0; m_integ = 0; m_dco = BIAS; m_valid = 0;
        pend.delete();
        outq.delete();
    endtask

    task automatic m_process(input samp_t s, input int dco_now);
        int mag, kp, ki, efix, p, inc, ctl, r;
        bit trk, frozen;
        out_t o;
        mag    = (s.e == -128) ? 127 : ((s.e < 0) ? -s.e : s.e);
        trk    = (s.st >= 2);
        kp     = trk ? 1 : 0;
        ki     = trk ? 4 : 2;
        efix   = s.e * 16;
        p      = efix >>> kp;
        inc    = efix >>> ki;
        frozen = (dco_now == 0 && s.e > 0) || (dco_now == DCOMAX && s.e < 0);
        if (!frozen) begin
            m_integ = m_integ + inc;
            if (m_integ > 32767) m_integ = 32767;
            if (m_integ < -32768) m_integ = -32768;
        end
        ctl = (m_integ + p) >>> 4;
        r   = BIAS - ctl;
        if (r < 0) r = 0;
        if (r > DCOMAX) r = DCOMAX;
        o.v = r;
        o.due = cyc + 1;
        outq.push_back(o);
        case (m_state)
            1: begin
                m_cnt = (mag <= 4) ? m_cnt + 1 : 0;
                if (m_cnt >= 4) begin m_state = 2; m_cnt = 0; end
            end
            2: begin
                if (mag > 4) begin m_state = 1; m_cnt = 0; end
                else begin
                    m_cnt = (mag <= 1) ? m_cnt + 1 : 0;
                    if (m_cnt >= 16) begin m_state = 3; m_cnt = 0; end
                end
            end
            3: begin
                if (mag > 4) begin m_state = 1; m_cnt = 0; end
                else if (mag > 1) begin m_state = 2; m_cnt = 0; end
            end
            default: ;
        endcase
    endtask

    task automatic m_edge(input bit r, input bit en, input bit v, input int e);
        int st0, dco0;
        samp_t s;
        cyc++;
        st0  = m_state;
        dco0 = m_dco;
        if (r || !en) begin
            m_flush();
        end else begin
            m_valid = 0;
            if (outq.size() > 0 && outq[0].due == cyc) begin
                m_dco = outq[0].v;
                m_valid = 1;
                void'(outq.pop_front());
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                s = pend.pop_front();
                m_process(s, dco0);
            end
            if (v && st0 != 0) begin
                s.e = e; s.st = st0; s.due = cyc + 1;
                pend.push_back(s);
            end
            if (st0 == 0) begin m_state = 1; m_cnt = 0; end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit r, input bit en, input bit v, input int e);
        reset_i = r; enable_i = en; error_valid_i = v; error_i = e[7:0];
        @(posedge clk);
        m_edge(r, en, v, e);
        #1;
        chk("dco_cc", int'(dco_cc_o), m_dco);
        chk("dco_valid", int'(dco_valid_o), m_valid);
        chk("state", int'(state_o), m_state);
        chk("locked", int'(locked_o), int'(m_state == 3));
    endtask

    // One sample then two idle cycles so its result is on the outputs.
    task automatic sample(input int e);
        tick(0, 1, 1, e);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
    endtask

    task automatic restart();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
    endtask

    initial begin
        reset_i = 1'b1; enable_i = 1'b0; error_valid_i = 1'b0; error_i = '0;

        // Reset and first acquisition sample
        tick(1, 0, 0, 0);
        chk("rst_dco", int'(dco_cc_o), BIAS);
        chk("rst_state", int'(state_o), 0);
        tick(0, 1, 0, 0);
        chk("en_acquire", int'(state_o), 1);
        sample(8);
        chk("t1_dco", int'(dco_cc_o), 6);
        chk("t1_valid", int'(dco_valid_o), 1);

        // Gear progression
        for (int i = 0; i < 4; i++) sample(0);
        chk("t2_track", int'(state_o), 2);
        for (int i = 0; i < 16; i++) sample(0);
        chk("t2_locked", int'(state_o), 3);
        chk("t2_locked_o", int'(locked_o), 1);
        sample(2);
        chk("t2_back_track", int'(state_o), 2);
        chk("t2_unlocked", int'(locked_o), 0);
        sample(5);
        chk("t2_back_acq", int'(state_o), 1);

        // Rails and anti-windup
        restart();
        sample(127);
        chk("t3_low_rail", int'(dco_cc_o), 0);
        for (int i = 0; i < 5; i++) sample(127);
        chk("t3_low_hold", int'(dco_cc_o), 0);
        sample(-127);
        chk("t3_high_rail", int'(dco_cc_o), DCOMAX);
        for (int i = 0; i < 3; i++) sample(-127);
        chk("t3_high_hold", int'(dco_cc_o), DCOMAX);

        // Most negative error in TRACK
        for (int i = 0; i < 4; i++) sample(0);
        chk("t4_track", int'(state_o), 2);
        sample(-128);
        chk("t4_acq", int'(state_o), 1);

        // Enable drop right after a sample
        tick(0, 1, 1, 3);
        tick(0, 0, 0, 0);
        chk("t5_idle", int'(state_o), 0);
        chk("t5_bias", int'(dco_cc_o), BIAS);
        tick(0, 1, 0, 0);
        chk("t5_novalid", int'(dco_valid_o), 0);
        chk("t5_reacq", int'(state_o), 1);
        tick(0, 1, 0, 0);
        chk("t5_novalid2", int'(dco_valid_o), 0);

        // Back-to-back samples across the gear change, then reset mid-stream
        restart();
        for (int i = 0; i < 10; i++) tick(0, 1, 1, 1);
        tick(0, 1, 1, 2);
        tick(1, 1, 1, 2);
        chk("t6_rst_dco", int'(dco_cc_o), BIAS);
        chk("t6_rst_valid", int'(dco_valid_o), 0);
        chk("t6_rst_state", int'(state_o), 0);
        tick(0, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, en, v;
            int e, cls;
            r   = ($urandom_range(0, 499) == 0);
            en  = ($urandom_range(0, 39) != 0);
            v   = ($urandom_range(0, 2) != 0);
            cls = $urandom_range(0, 3);
            if (cls < 2)       e = int'($urandom_range(0, 4)) - 2;
            else if (cls == 2) e = int'($urandom_range(0, 12)) - 6;
            else               e = int'($urandom_range(0, 255)) - 128;
            tick(r, en, v, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
